// File: rtl/reg_xfer_sequencer_if.sv
// Command/completion handshake and register-file access port of the GB80 register-transfer sequencer.
// The master modport is the sequencer's view; slave is the view of the control logic plus register file.
interface reg_xfer_sequencer_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
);
  logic                      i_cmd_valid;
  logic                      o_cmd_ready;
  logic [2:0]                i_cmd_op;
  logic [ADDRESS_WIDTH-1:0]  i_cmd_src;
  logic [ADDRESS_WIDTH-1:0]  i_cmd_dst;
  logic [2*DATA_WIDTH-1:0]   i_cmd_imm;
  logic                      o_done;
  logic                      o_err;
  logic [2*DATA_WIDTH-1:0]   o_result;
  logic                      o_rf_wr_en;
  logic                      o_rf_wr_addr_en;
  logic                      o_rf_rd_en;
  logic                      o_rf_rd_addr_en;
  logic [ADDRESS_WIDTH-1:0]  o_rf_addr;
  logic [DATA_WIDTH-1:0]     o_rf_data;
  logic [2*DATA_WIDTH-1:0]   o_rf_addr_data;
  logic [DATA_WIDTH-1:0]     i_rf_data;
  logic [2*DATA_WIDTH-1:0]   i_rf_addr_data;

  modport master (
    input  i_cmd_valid, i_cmd_op, i_cmd_src, i_cmd_dst, i_cmd_imm,
    input  i_rf_data, i_rf_addr_data,
    output o_cmd_ready, o_done, o_err, o_result,
    output o_rf_wr_en, o_rf_wr_addr_en, o_rf_rd_en, o_rf_rd_addr_en,
    output o_rf_addr, o_rf_data, o_rf_addr_data
  );

  modport slave (
    output i_cmd_valid, i_cmd_op, i_cmd_src, i_cmd_dst, i_cmd_imm,
    output i_rf_data, i_rf_addr_data,
    input  o_cmd_ready, o_done, o_err, o_result,
    input  o_rf_wr_en, o_rf_wr_addr_en, o_rf_rd_en, o_rf_rd_addr_en,
    input  o_rf_addr, o_rf_data, o_rf_addr_data
  );
endinterface

// File: rtl/reg_xfer_sequencer.sv
// Register-transfer sequencer: turns one captured transfer command into a timed series of
// register-file reads and writes over the single shared access port.
module reg_xfer_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  reg_xfer_sequencer_if.master bus
);
  localparam int PAIR_WIDTH = 2 * DATA_WIDTH;

  localparam logic [2:0] OP_MOV8  = 3'd0;
  localparam logic [2:0] OP_LDI8  = 3'd1;
  localparam logic [2:0] OP_LD16  = 3'd2;
  localparam logic [2:0] OP_INC16 = 3'd3;
  localparam logic [2:0] OP_DEC16 = 3'd4;
  localparam logic [2:0] OP_SWAP8 = 3'd5;

  localparam logic [ADDRESS_WIDTH-1:0] REG_MEM  = ADDRESS_WIDTH'(6);
  localparam logic [ADDRESS_WIDTH-1:0] PAIR_PC  = ADDRESS_WIDTH'(3);
  localparam logic [ADDRESS_WIDTH-1:0] PAIR_MAX = ADDRESS_WIDTH'(3);

  typedef enum logic [3:0] {
    IDLE, RD_A, RD_B, RD_PAIR, WR_HI, WR_LO, WR_A, WR_B, WR_PC
  } state_e;

  state_e                   state_reg, state_next;
  logic [2:0]               op_reg;
  logic [ADDRESS_WIDTH-1:0] src_reg, dst_reg;
  logic [PAIR_WIDTH-1:0]    imm_reg;
  logic [DATA_WIDTH-1:0]    a_reg, b_reg;
  logic [PAIR_WIDTH-1:0]    wval_reg;
  logic                     done_reg, err_reg;
  logic [PAIR_WIDTH-1:0]    result_reg, result_next;

  logic accept, cmd_illegal, last_access;

  logic                     wr_en, wr_addr_en, rd_en, rd_addr_en;
  logic [ADDRESS_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0]    rf_data;
  logic [PAIR_WIDTH-1:0]    rf_addr_data;

  assign accept      = (state_reg == IDLE) && bus.i_cmd_valid;
  assign last_access = (state_reg != IDLE) && (state_next == IDLE);

  always_comb begin
    cmd_illegal = 1'b0;
    case (bus.i_cmd_op)
      OP_MOV8, OP_SWAP8:          cmd_illegal = (bus.i_cmd_src == REG_MEM) || (bus.i_cmd_dst == REG_MEM);
      OP_LDI8:                    cmd_illegal = (bus.i_cmd_dst == REG_MEM);
      OP_LD16, OP_INC16, OP_DEC16: cmd_illegal = (bus.i_cmd_dst > PAIR_MAX);
      default:                    cmd_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.i_cmd_valid && !cmd_illegal) begin
          case (bus.i_cmd_op)
            OP_MOV8, OP_SWAP8:  state_next = RD_A;
            OP_LDI8:            state_next = WR_B;
            OP_LD16:            state_next = (bus.i_cmd_dst == PAIR_PC) ? WR_PC : WR_HI;
            OP_INC16, OP_DEC16: state_next = RD_PAIR;
            default:            state_next = IDLE;
          endcase
        end
      end
      RD_A:    state_next = (op_reg == OP_SWAP8) ? RD_B : WR_B;
      RD_B:    state_next = WR_A;
      RD_PAIR: state_next = (dst_reg == PAIR_PC) ? WR_PC : WR_HI;
      WR_HI:   state_next = WR_LO;
      WR_A:    state_next = WR_B;
      default: state_next = IDLE;
    endcase
  end

  // Port drive depends only on registered state and operands, never on the live command.
  always_comb begin
    wr_en        = 1'b0;
    wr_addr_en   = 1'b0;
    rd_en        = 1'b0;
    rd_addr_en   = 1'b0;
    rf_addr      = '0;
    rf_data      = '0;
    rf_addr_data = '0;
    case (state_reg)
      RD_A: begin
        rd_en   = 1'b1;
        rf_addr = src_reg;
      end
      RD_B: begin
        rd_en   = 1'b1;
        rf_addr = dst_reg;
      end
      RD_PAIR: begin
        rd_addr_en = 1'b1;
        rf_addr    = dst_reg;
      end
      WR_HI: begin
        wr_en   = 1'b1;
        rf_addr = {dst_reg[ADDRESS_WIDTH-2:0], 1'b0};
        rf_data = wval_reg[PAIR_WIDTH-1:DATA_WIDTH];
      end
      WR_LO: begin
        wr_en   = 1'b1;
        rf_addr = {dst_reg[ADDRESS_WIDTH-2:0], 1'b1};
        rf_data = wval_reg[DATA_WIDTH-1:0];
      end
      WR_A: begin
        wr_en   = 1'b1;
        rf_addr = dst_reg;
        rf_data = a_reg;
      end
      WR_B: begin
        wr_en   = 1'b1;
        rf_addr = (op_reg == OP_SWAP8) ? src_reg : dst_reg;
        case (op_reg)
          OP_MOV8:  rf_data = a_reg;
          OP_SWAP8: rf_data = b_reg;
          default:  rf_data = imm_reg[DATA_WIDTH-1:0];
        endcase
      end
      WR_PC: begin
        wr_addr_en   = 1'b1;
        rf_addr      = dst_reg;
        rf_addr_data = wval_reg;
      end
      default: ;
    endcase
  end

  always_comb begin
    result_next = result_reg;
    case (op_reg)
      OP_MOV8:                     result_next = {{DATA_WIDTH{1'b0}}, a_reg};
      OP_LDI8:                     result_next = {{DATA_WIDTH{1'b0}}, imm_reg[DATA_WIDTH-1:0]};
      OP_LD16, OP_INC16, OP_DEC16: result_next = wval_reg;
      OP_SWAP8:                    result_next = {a_reg, b_reg};
      default:                     result_next = result_reg;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      src_reg    <= '0;
      dst_reg    <= '0;
      imm_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      wval_reg   <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      if (accept) begin
        op_reg   <= bus.i_cmd_op;
        src_reg  <= bus.i_cmd_src;
        dst_reg  <= bus.i_cmd_dst;
        imm_reg  <= bus.i_cmd_imm;
        wval_reg <= bus.i_cmd_imm;
        if (cmd_illegal) begin
          done_reg <= 1'b1;
          err_reg  <= 1'b1;
        end
      end
      case (state_reg)
        RD_A:    a_reg <= bus.i_rf_data;
        RD_B:    b_reg <= bus.i_rf_data;
        // Wraps naturally: FFFF+1 gives 0000, 0000-1 gives FFFF.
        RD_PAIR: wval_reg <= (op_reg == OP_INC16) ? bus.i_rf_addr_data + PAIR_WIDTH'(1)
                                                  : bus.i_rf_addr_data - PAIR_WIDTH'(1);
        default: ;
      endcase
      if (last_access) begin
        done_reg   <= 1'b1;
        result_reg <= result_next;
      end
    end
  end

  assign bus.o_cmd_ready     = (state_reg == IDLE);
  assign bus.o_done          = done_reg;
  assign bus.o_err           = err_reg;
  assign bus.o_result        = result_reg;
  assign bus.o_rf_wr_en      = wr_en;
  assign bus.o_rf_wr_addr_en = wr_addr_en;
  assign bus.o_rf_rd_en      = rd_en;
  assign bus.o_rf_rd_addr_en = rd_addr_en;
  assign bus.o_rf_addr       = rf_addr;
  assign bus.o_rf_data       = rf_data;
  assign bus.o_rf_addr_data  = rf_addr_data;
endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Directed bench for reg_xfer_sequencer with a behavioural register file behind the access port.
// Each access is logged as {kind, 0, addr, data16}: kind 1 wr, 2 wr_addr, 3 rd, 4 rd_addr.
module tb_reg_xfer_sequencer;
  localparam logic [2:0] OP_MOV8  = 3'd0;
  localparam logic [2:0] OP_LDI8  = 3'd1;
  localparam logic [2:0] OP_LD16  = 3'd2;
  localparam logic [2:0] OP_INC16 = 3'd3;
  localparam logic [2:0] OP_DEC16 = 3'd4;
  localparam logic [2:0] OP_SWAP8 = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_xfer_sequencer_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3)) bus ();

  reg_xfer_sequencer #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  logic [7:0]  rf [8] = '{default: 8'h00};
  logic [15:0] pc = 16'h0000;
  int          wr_count = 0;

  always_comb begin
    bus.i_rf_data      = 8'h00;
    bus.i_rf_addr_data = 16'h0000;
    if (bus.o_rf_rd_en)
      bus.i_rf_data = rf[bus.o_rf_addr];
    if (bus.o_rf_rd_addr_en)
      bus.i_rf_addr_data = (bus.o_rf_addr == 3'd3) ? pc
                         : {rf[{bus.o_rf_addr[1:0], 1'b0}], rf[{bus.o_rf_addr[1:0], 1'b1}]};
  end

  always @(posedge clk) begin
    if (bus.o_rf_wr_en) begin
      rf[bus.o_rf_addr] <= bus.o_rf_data;
      wr_count <= wr_count + 1;
    end
    if (bus.o_rf_wr_addr_en) begin
      pc <= bus.o_rf_addr_data;
      wr_count <= wr_count + 1;
    end
  end

  int          n_checks = 0;
  int          n_fail = 0;
  logic [23:0] acc [8];
  int          n_acc, lat;
  logic        got_err, rdy_at_done, busy_ready, multi, strobes_at_done;

  task automatic issue(input logic [2:0] op, input logic [2:0] src, input logic [2:0] dst,
                       input logic [15:0] imm);
    logic [3:0]  kind;
    logic [15:0] data;
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = op;
    bus.i_cmd_src   = src;
    bus.i_cmd_dst   = dst;
    bus.i_cmd_imm   = imm;
    @(posedge clk);
    #1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = 3'd0;
    bus.i_cmd_src   = 3'd0;
    bus.i_cmd_dst   = 3'd0;
    bus.i_cmd_imm   = 16'h0000;
    n_acc = 0; lat = 0; got_err = 0; rdy_at_done = 0;
    busy_ready = 0; multi = 0; strobes_at_done = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.o_done) begin
        lat = c;
        got_err = bus.o_err;
        rdy_at_done = bus.o_cmd_ready;
        strobes_at_done = bus.o_rf_wr_en | bus.o_rf_wr_addr_en | bus.o_rf_rd_en | bus.o_rf_rd_addr_en;
        break;
      end
      if (bus.o_cmd_ready) busy_ready = 1;
      if ((int'(bus.o_rf_wr_en) + int'(bus.o_rf_wr_addr_en) + int'(bus.o_rf_rd_en)
           + int'(bus.o_rf_rd_addr_en)) != 1) multi = 1;
      kind = 4'd0;
      data = 16'h0000;
      if (bus.o_rf_wr_en) begin kind = 4'd1; data = {8'h00, bus.o_rf_data}; end
      else if (bus.o_rf_wr_addr_en) begin kind = 4'd2; data = bus.o_rf_addr_data; end
      else if (bus.o_rf_rd_en) kind = 4'd3;
      else if (bus.o_rf_rd_addr_en) kind = 4'd4;
      if (n_acc < 8) acc[n_acc] = {kind, 1'b0, bus.o_rf_addr, data};
      n_acc++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (lat == 0) begin
      n_fail++;
      $display("FAIL done_timeout: op=%0d no o_done within 20 cycles, required a pulse", op);
    end
  endtask

  task automatic test_reset();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op = 3'd0; bus.i_cmd_src = 3'd0; bus.i_cmd_dst = 3'd0; bus.i_cmd_imm = 16'h0000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.o_cmd_ready, bus.o_done, bus.o_err} !== 3'b100 || bus.o_result !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/done/err=%b result=%h, required 100 0000",
               {bus.o_cmd_ready, bus.o_done, bus.o_err}, bus.o_result);
    end
    n_checks++;
    if ({bus.o_rf_wr_en, bus.o_rf_wr_addr_en, bus.o_rf_rd_en, bus.o_rf_rd_addr_en,
         bus.o_rf_addr, bus.o_rf_data, bus.o_rf_addr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_port: strobes=%b addr=%h data=%h addr_data=%h, required all 0",
               {bus.o_rf_wr_en, bus.o_rf_wr_addr_en, bus.o_rf_rd_en, bus.o_rf_rd_addr_en},
               bus.o_rf_addr, bus.o_rf_data, bus.o_rf_addr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mov8();
    issue(OP_LDI8, 3'd0, 3'd0, 16'hAB12);
    n_checks++;
    if (n_acc != 1 || acc[0] !== 24'h100012 || lat != 2 || bus.o_result !== 16'h0012 || got_err) begin
      n_fail++;
      $display("FAIL ldi8_b: n=%0d acc0=%h lat=%0d result=%h err=%b, required 1 100012 2 0012 0",
               n_acc, acc[0], lat, bus.o_result, got_err);
    end
    issue(OP_MOV8, 3'd0, 3'd7, 16'hBEEF);
    n_checks++;
    if (n_acc != 2 || acc[0] !== 24'h300000 || acc[1] !== 24'h170012 || lat != 3 || multi) begin
      n_fail++;
      $display("FAIL mov8_seq: n=%0d acc=%h %h lat=%0d multi=%b, required 2 300000 170012 3 0",
               n_acc, acc[0], acc[1], lat, multi);
    end
    n_checks++;
    if (bus.o_result !== 16'h0012 || rf[7] !== 8'h12) begin
      n_fail++;
      $display("FAIL mov8_result: result=%h A=%h, required 0012 12", bus.o_result, rf[7]);
    end
  endtask

  task automatic test_inc16();
    issue(OP_LD16, 3'd0, 3'd2, 16'hFFFF);
    n_checks++;
    if (n_acc != 2 || acc[0] !== 24'h1400FF || acc[1] !== 24'h1500FF || lat != 3 || bus.o_result !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL ld16_hl: n=%0d acc=%h %h lat=%0d result=%h, required 2 1400ff 1500ff 3 ffff",
               n_acc, acc[0], acc[1], lat, bus.o_result);
    end
    issue(OP_INC16, 3'd0, 3'd2, 16'h7777);
    n_checks++;
    if (n_acc != 3 || acc[0] !== 24'h420000 || acc[1] !== 24'h140000 || acc[2] !== 24'h150000 || lat != 4) begin
      n_fail++;
      $display("FAIL inc16_seq: n=%0d acc=%h %h %h lat=%0d, required 3 420000 140000 150000 4",
               n_acc, acc[0], acc[1], acc[2], lat);
    end
    n_checks++;
    if (bus.o_result !== 16'h0000 || rf[4] !== 8'h00 || rf[5] !== 8'h00) begin
      n_fail++;
      $display("FAIL inc16_wrap: result=%h H=%h L=%h, required 0000 00 00", bus.o_result, rf[4], rf[5]);
    end
  endtask

  task automatic test_dec16_pc();
    issue(OP_LD16, 3'd0, 3'd0, 16'h0000);
    issue(OP_DEC16, 3'd0, 3'd0, 16'h0000);
    n_checks++;
    if (n_acc != 3 || acc[0] !== 24'h400000 || acc[1] !== 24'h1000FF || acc[2] !== 24'h1100FF
        || bus.o_result !== 16'hFFFF || rf[0] !== 8'hFF || rf[1] !== 8'hFF) begin
      n_fail++;
      $display("FAIL dec16_wrap: n=%0d acc=%h %h %h result=%h B=%h C=%h, required 3 400000 1000ff 1100ff ffff ff ff",
               n_acc, acc[0], acc[1], acc[2], bus.o_result, rf[0], rf[1]);
    end
    issue(OP_LD16, 3'd0, 3'd3, 16'h1234);
    n_checks++;
    if (n_acc != 1 || acc[0] !== 24'h231234 || lat != 2 || bus.o_result !== 16'h1234 || pc !== 16'h1234) begin
      n_fail++;
      $display("FAIL ld16_pc: n=%0d acc0=%h lat=%0d result=%h pc=%h, required 1 231234 2 1234 1234",
               n_acc, acc[0], lat, bus.o_result, pc);
    end
    issue(OP_INC16, 3'd0, 3'd3, 16'h0000);
    n_checks++;
    if (n_acc != 2 || acc[0] !== 24'h430000 || acc[1] !== 24'h231235 || lat != 3 || bus.o_result !== 16'h1235) begin
      n_fail++;
      $display("FAIL inc16_pc: n=%0d acc=%h %h lat=%0d result=%h, required 2 430000 231235 3 1235",
               n_acc, acc[0], acc[1], lat, bus.o_result);
    end
  endtask

  task automatic test_swap8();
    issue(OP_LDI8, 3'd0, 3'd2, 16'h005A);
    issue(OP_LDI8, 3'd0, 3'd3, 16'h00A5);
    issue(OP_SWAP8, 3'd2, 3'd3, 16'h0000);
    n_checks++;
    if (n_acc != 4 || acc[0] !== 24'h320000 || acc[1] !== 24'h330000 || acc[2] !== 24'h13005A
        || acc[3] !== 24'h1200A5 || lat != 5) begin
      n_fail++;
      $display("FAIL swap8_seq: n=%0d acc=%h %h %h %h lat=%0d, required 4 320000 330000 13005a 1200a5 5",
               n_acc, acc[0], acc[1], acc[2], acc[3], lat);
    end
    n_checks++;
    if (bus.o_result !== 16'h5AA5 || rf[2] !== 8'hA5 || rf[3] !== 8'h5A) begin
      n_fail++;
      $display("FAIL swap8_result: result=%h D=%h E=%h, required 5aa5 a5 5a", bus.o_result, rf[2], rf[3]);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] op, src, dst;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin op = OP_MOV8;  src = 3'd0; dst = 3'd6; end
        1:       begin op = OP_INC16; src = 3'd0; dst = 3'd5; end
        2:       begin op = 3'd7;     src = 3'd0; dst = 3'd0; end
        default: begin op = OP_SWAP8; src = 3'd6; dst = 3'd1; end
      endcase
      issue(op, src, dst, 16'hCCCC);
      n_checks++;
      if (n_acc != 0 || lat != 1 || !got_err || strobes_at_done || bus.o_result !== 16'h5AA5) begin
        n_fail++;
        $display("FAIL illegal_%0d: n=%0d lat=%0d err=%b strobes=%b result=%h, required 0 1 1 0 5aa5",
                 i, n_acc, lat, got_err, strobes_at_done, bus.o_result);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(OP_MOV8, 3'd3, 3'd4, 16'h0000);
    n_checks++;
    if (!rdy_at_done || busy_ready || multi || got_err || rf[4] !== 8'h5A) begin
      n_fail++;
      $display("FAIL b2b_first: rdy_done=%b busy_ready=%b multi=%b err=%b H=%h, required 1 0 0 0 5a",
               rdy_at_done, busy_ready, multi, got_err, rf[4]);
    end
    issue(OP_LDI8, 3'd0, 3'd5, 16'h0033);
    n_checks++;
    if (lat != 2 || bus.o_result !== 16'h0033 || rf[5] !== 8'h33) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d result=%h L=%h, required 2 0033 33", lat, bus.o_result, rf[5]);
    end
  endtask

  task automatic test_reset_midflight();
    int wr_before;
    wr_before = wr_count;
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op = OP_SWAP8; bus.i_cmd_src = 3'd2; bus.i_cmd_dst = 3'd3;
    @(posedge clk);
    #1;
    bus.i_cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (!bus.o_rf_rd_en || bus.o_rf_addr !== 3'd3) begin
      n_fail++;
      $display("FAIL midflight_rd_b: rd_en=%b addr=%h, required 1 3", bus.o_rf_rd_en, bus.o_rf_addr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_rf_wr_en, bus.o_rf_wr_addr_en, bus.o_rf_rd_en, bus.o_rf_rd_addr_en} !== 4'b0000
        || bus.o_rf_addr !== 3'd0 || !bus.o_cmd_ready || bus.o_done || bus.o_result !== 16'h0000) begin
      n_fail++;
      $display("FAIL midflight_reset: strobes=%b addr=%h ready=%b done=%b result=%h, required 0000 0 1 0 0000",
               {bus.o_rf_wr_en, bus.o_rf_wr_addr_en, bus.o_rf_rd_en, bus.o_rf_rd_addr_en},
               bus.o_rf_addr, bus.o_cmd_ready, bus.o_done, bus.o_result);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (wr_count != wr_before || rf[2] !== 8'hA5 || rf[3] !== 8'h5A || bus.o_done) begin
      n_fail++;
      $display("FAIL midflight_regs: writes=%0d D=%h E=%h done=%b, required %0d a5 5a 0",
               wr_count - wr_before, rf[2], rf[3], bus.o_done, 0);
    end
    issue(OP_LDI8, 3'd0, 3'd7, 16'h0099);
    n_checks++;
    if (lat != 2 || bus.o_result !== 16'h0099 || rf[7] !== 8'h99) begin
      n_fail++;
      $display("FAIL post_reset_ldi8: lat=%0d result=%h A=%h, required 2 0099 99", lat, bus.o_result, rf[7]);
    end
  endtask

  initial begin
    test_reset();
    test_mov8();
    test_inc16();
    test_dec16_pc();
    test_swap8();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_xfer_sequencer.md
# reg_xfer_sequencer

Register-transfer sequencer for the GB80 core: the initiator that drives the register file's single shared access port. It accepts one transfer command at a time from the decode/control logic and issues the timed sequence of register-file reads and writes for it: 8-bit moves, immediate loads, 16-bit pair loads, pair increment/decrement and register swaps. It sits between the instruction control unit and the register file, so control logic never hand-sequences multi-cycle register accesses.

## Interface
- DATA_WIDTH, 8, width of one general register; pair width is 2*DATA_WIDTH
- ADDRESS_WIDTH, 3, register/pair code width

- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  sequencer can accept a command
- i_cmd_op  in  3  0 MOV8, 1 LDI8, 2 LD16, 3 INC16, 4 DEC16, 5 SWAP8, 6-7 illegal
- i_cmd_src  in  ADDRESS_WIDTH  8-bit source register code
- i_cmd_dst  in  ADDRESS_WIDTH  8-bit destination code, or pair code for LD16/INC16/DEC16
- i_cmd_imm  in  2*DATA_WIDTH  immediate (LDI8 uses [7:0])
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  one-cycle pulse with o_done for a rejected command
- o_result  out  2*DATA_WIDTH  value(s) written by the last completed command
- o_rf_wr_en, o_rf_wr_addr_en, o_rf_rd_en, o_rf_rd_addr_en  out  1 each  register-file strobes
- o_rf_addr  out  ADDRESS_WIDTH  register/pair code
- o_rf_data  out  DATA_WIDTH  8-bit write data
- o_rf_addr_data  out  2*DATA_WIDTH  16-bit write data (PC)
- i_rf_data  in  DATA_WIDTH  combinational 8-bit read data
- i_rf_addr_data  in  2*DATA_WIDTH  combinational pair read data, {high, low}

## Operation
- Register codes: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 memory (illegal), 7 A. Pair codes: 0 BC, 1 DE, 2 HL, 3 PC, 4-7 illegal. Pair high register = even code (B/D/H), low = odd (C/E/L); pair n maps to registers 2n and 2n+1.
- Accept when i_cmd_valid & o_cmd_ready at a rising edge; all i_cmd_* are captured then and ignored afterwards.
- States: IDLE, RD_A, RD_B, RD_PAIR, WR_HI, WR_LO, WR_A, WR_B, WR_PC. Exactly one strobe is high in each non-IDLE state; none in IDLE.
- MOV8: RD_A (rd_en, addr=src, capture i_rf_data) -> WR_B (wr_en, addr=dst, data=captured). src==dst is legal.
- LDI8: WR_B (addr=dst, data=imm[7:0]).
- LD16 pairs 0-2: WR_HI (addr=2n, data=imm[15:8]) -> WR_LO (addr=2n+1, data=imm[7:0]). Pair 3: WR_PC (wr_addr_en, addr_data=imm).
- INC16/DEC16: RD_PAIR (rd_addr_en, addr=pair, capture i_rf_addr_data), computed value = captured ±1 mod 2^16 (FFFF+1=0000, 0000-1=FFFF); then WR_HI -> WR_LO, or WR_PC for pair 3.
- SWAP8: RD_A (src) -> RD_B (dst) -> WR_A (addr=dst, data=old src) -> WR_B (addr=src, data=old dst). src==dst legal.
- Illegal: op 6/7, 8-bit code 6 on any 8-bit operand, pair code >3. No strobes issued; o_done and o_err pulse the cycle after acceptance.
- o_result: MOV8/LDI8 {00, written byte}; pair ops the 16-bit value written; SWAP8 {new dst, new src}; held until the next o_done; unchanged on error.
- Strobes, o_rf_addr, o_rf_data and o_rf_addr_data are decoded from registered state/operands only; no combinational path from i_cmd_* to them. Inactive data/address outputs are 0.

## Timing
- Reset (async assert): state IDLE, o_cmd_ready=1, o_done=0, o_err=0, o_result=0, all strobes and o_rf_* outputs 0 immediately. An in-flight command is abandoned; writes already issued remain.
- o_cmd_ready=1 only in IDLE.
- Access cycles after acceptance: LDI8 1, MOV8 2, LD16 2 (PC 1), INC16/DEC16 3 (PC 2), SWAP8 4.
- o_done pulses in the first IDLE cycle after the final access, with o_cmd_ready=1, so a back-to-back command can be accepted in that cycle.
- Read data is sampled at the rising edge that ends the read state.

## Test plan
- LDI8 dst=0 imm=0012, then MOV8 src=0 dst=7 -> wr_en cycle with addr 7, data 12; o_result=0012; A reads 12.
- LD16 pair 2 imm=FFFF, then INC16 pair 2 -> RD_PAIR, WR_HI addr 4 data 00, WR_LO addr 5 data 00; o_done 4 cycles after accept; o_result=0000.
- LD16 pair 0 imm=0000, then DEC16 pair 0 -> B=FF, C=FF, o_result=FFFF; LD16 pair 3 imm=1234 -> single wr_addr_en cycle, addr_data=1234.
- D=5A, E=A5; SWAP8 src=2 dst=3 -> writes addr 3 data 5A, then addr 2 data A5; o_result=5AA5.
- MOV8 dst=6, INC16 pair 5, op 7 -> each gives o_done=o_err=1 one cycle after accept, no strobes, o_result unchanged.
- Assert i_reset low during RD_B of SWAP8 -> strobes drop same cycle, no writes, o_cmd_ready=1; D/E unchanged after release.
